t_ff_bank: RTL and testbench

Parametrised bank of WIDTH toggle flip-flops with a shared clock, synchronous reset and enable. It extends the single-bit T flip-flop in four ways: per-bit toggle and set modes, chained-T up/down counting, parallel load, and a registered terminal-count pulse. It is the general-purpose toggle, flag and counter primitive for control logic in this codebase.

---
 rtl/t_ff_bank.sv | 95 +++++++++
 tb/tb_t_ff_bank.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/t_ff_bank.sv
// Bank of WIDTH toggle flip-flops with toggle, sticky-set, chained-T up/down
// counting, parallel load and a registered terminal-count pulse.
module t_ff_bank #(
    parameter int unsigned           WIDTH     = 8,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0,
    parameter bit                    SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] T,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic             tc
);

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'd0,
        MODE_SET    = 2'd1,
        MODE_UP     = 2'd2,
        MODE_DOWN   = 2'd3
    } mode_e;

    mode_e            mode_sel;
    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] up_tgl;
    logic [WIDTH-1:0] dn_tgl;
    logic             at_max;
    logic             at_min;

    assign mode_sel = mode_e'(mode);

    // Chained-T toggle enables: bit i flips when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        up_tgl    = '0;
        dn_tgl    = '0;
        up_tgl[0] = 1'b1;
        dn_tgl[0] = 1'b1;
        for (int i = 1; i < int'(WIDTH); i++) begin
            up_tgl[i] = up_tgl[i-1] & q_q[i-1];
            dn_tgl[i] = dn_tgl[i-1] & ~q_q[i-1];
        end
    end

    assign at_max = &q_q;
    assign at_min = ~|q_q;

    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        if (load) begin
            q_d = load_val;
        end else if (enable) begin
            case (mode_sel)
                MODE_TOGGLE: q_d = q_q ^ T;
                MODE_SET:    q_d = q_q | T;
                MODE_UP: begin
                    if (T[0]) begin
                        tc_d = at_max;
                        // All-ones toggles every bit, so wrap to zero falls out naturally.
                        if (!(SATURATE && at_max)) begin
                            q_d = q_q ^ up_tgl;
                        end
                    end
                end
                MODE_DOWN: begin
                    if (T[0]) begin
                        tc_d = at_min;
                        if (!(SATURATE && at_min)) begin
                            q_d = q_q ^ dn_tgl;
                        end
                    end
                end
                default: q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q  <= RESET_VAL;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    assign Q  = q_q;
    assign tc = tc_q;

endmodule

// File: tb/tb_t_ff_bank.sv
// Bench for t_ff_bank: three WIDTH=4 instances (wrap, saturate, RESET_VAL=1010)
// share stimulus; a reference model fills an expected queue checked after each edge.
module tb_t_ff_bank;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         enable;
  logic [1:0]   mode;
  logic [W-1:0] t_in;
  logic         load;
  logic [W-1:0] load_val;

  logic [W-1:0] q_a, q_s, q_r;
  logic         tc_a, tc_s, tc_r;

  logic [W-1:0] m_a, m_s, m_r;
  logic [W:0]   exp_q[$];

  int n_checks;
  int n_pass;

  t_ff_bank #(.WIDTH(W), .RESET_VAL(4'b0000), .SATURATE(1'b0)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .T(t_in),
    .load(load), .load_val(load_val), .Q(q_a), .tc(tc_a)
  );

  t_ff_bank #(.WIDTH(W), .RESET_VAL(4'b0000), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .T(t_in),
    .load(load), .load_val(load_val), .Q(q_s), .tc(tc_s)
  );

  t_ff_bank #(.WIDTH(W), .RESET_VAL(4'b1010), .SATURATE(1'b0)) dut_r (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .T(t_in),
    .load(load), .load_val(load_val), .Q(q_r), .tc(tc_r)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [W:0] observed, input logic [W:0] expected);
    n_checks++;
    if (observed === expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got tc=%b q=%b, expected tc=%b q=%b",
               tag, observed[W], observed[W-1:0], expected[W], expected[W-1:0]);
    end
  endtask

  // Reference model written from the arithmetic description: returns {tc, q}.
  function automatic logic [W:0] model(input logic [W-1:0] q, input bit sat, input logic [W-1:0] rv,
                                       input logic r, input logic en, input logic [1:0] md,
                                       input logic [W-1:0] tv, input logic ld, input logic [W-1:0] lv);
    if (r)   return {1'b0, rv};
    if (ld)  return {1'b0, lv};
    if (!en) return {1'b0, q};
    case (md)
      2'd0: return {1'b0, q ^ tv};
      2'd1: return {1'b0, q | tv};
      2'd2: begin
        if (!tv[0]) return {1'b0, q};
        if (q == 4'hF) return sat ? {1'b1, q} : {1'b1, 4'h0};
        return {1'b0, q + 4'd1};
      end
      default: begin
        if (!tv[0]) return {1'b0, q};
        if (q == 4'h0) return sat ? {1'b1, q} : {1'b1, 4'hF};
        return {1'b0, q - 4'd1};
      end
    endcase
  endfunction

  // driver: one edge of stimulus, expected values queued, DUT outputs checked after the edge
  task automatic step(input string tag, input logic r, input logic en, input logic [1:0] md,
                      input logic [W-1:0] tv, input logic ld, input logic [W-1:0] lv);
    logic [W:0] e;
    @(negedge clk);
    reset    = r;
    enable   = en;
    mode     = md;
    t_in     = tv;
    load     = ld;
    load_val = lv;
    e = model(m_a, 1'b0, 4'b0000, r, en, md, tv, ld, lv); exp_q.push_back(e); m_a = e[W-1:0];
    e = model(m_s, 1'b1, 4'b0000, r, en, md, tv, ld, lv); exp_q.push_back(e); m_s = e[W-1:0];
    e = model(m_r, 1'b0, 4'b1010, r, en, md, tv, ld, lv); exp_q.push_back(e); m_r = e[W-1:0];
    @(posedge clk);
    #1;
    check({tag, "/wrap"}, {tc_a, q_a}, exp_q.pop_front());
    check({tag, "/sat"},  {tc_s, q_s}, exp_q.pop_front());
    check({tag, "/rv"},   {tc_r, q_r}, exp_q.pop_front());
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_a = '0; m_s = '0; m_r = '0;
    reset = 1'b1; enable = 1'b0; mode = 2'd0; t_in = '0; load = 1'b0; load_val = '0;

    step("reset0", 1, 0, 0, 4'b0000, 0, 4'b0000);
    step("reset1", 1, 1, 2, 4'b1111, 1, 4'b0110);

    // toggle mode, then hold with enable low
    step("tog1", 0, 1, 0, 4'b0101, 0, 4'b0000);
    step("tog2", 0, 1, 0, 4'b0101, 0, 4'b0000);
    step("hold", 0, 0, 0, 4'b1111, 0, 4'b0000);

    // sticky set then toggle
    step("set1", 0, 1, 1, 4'b0001, 0, 4'b0000);
    step("set2", 0, 1, 1, 4'b1000, 0, 4'b0000);
    step("set_tog", 0, 1, 0, 4'b0001, 0, 4'b0000);

    // up count through the wrap, with a strobe-low pause
    step("up_rst", 1, 0, 0, 4'b0000, 0, 4'b0000);
    for (int i = 0; i < 17; i++) step($sformatf("up%0d", i), 0, 1, 2, 4'b0001, 0, 4'b0000);
    step("up_nostrobe", 0, 1, 2, 4'b1110, 0, 4'b0000);
    step("up_resume", 0, 1, 2, 4'b0001, 0, 4'b0000);

    // down count from 1 through the underflow; saturating bank sticks at 0
    step("dn_load", 0, 1, 3, 4'b0000, 1, 4'b0001);
    for (int i = 0; i < 4; i++) step($sformatf("dn%0d", i), 0, 1, 3, 4'b0001, 0, 4'b0000);

    // load wins over a wrapping count, even with enable low
    step("ld_max", 0, 0, 0, 4'b0000, 1, 4'b1111);
    step("ld_prec", 0, 0, 2, 4'b0001, 1, 4'b0110);
    step("ld_max2", 0, 1, 0, 4'b0000, 1, 4'b1111);
    step("ld_wrap", 0, 1, 2, 4'b0001, 1, 4'b0110);

    // reset on the would-wrap edge, then counting resumes from RESET_VAL
    step("rst_ld", 0, 1, 0, 4'b0000, 1, 4'b1111);
    step("rst_wrap", 1, 1, 2, 4'b0001, 0, 4'b0000);
    step("rst_cnt1", 0, 1, 2, 4'b0001, 0, 4'b0000);
    step("rst_cnt2", 0, 1, 2, 4'b0001, 0, 4'b0000);

    // saturating up at all-ones holds tc on every request
    step("sat_ld", 0, 1, 0, 4'b0000, 1, 4'b1110);
    for (int i = 0; i < 3; i++) step($sformatf("satup%0d", i), 0, 1, 2, 4'b0001, 0, 4'b0000);

    // random mix
    for (int i = 0; i < 80; i++) begin
      step($sformatf("rnd%0d", i),
           logic'($urandom_range(0, 15) == 0),
           logic'($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)),
           logic'($urandom_range(0, 9) == 0),
           4'($urandom_range(0, 15)));
    end

    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
